// File: rtl/parking_request_scheduler.sv
// Front-end scheduler for the parking elevator: queues entry/exit plates in two FIFOs,
// arbitrates with a bounded exit burst, and issues one request at a time with a done timeout.
module parking_request_scheduler #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned OUT_BURST = 2,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned CW        = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_mode,
    input  logic          out_mode,
    input  logic [15:0]   license_plate,
    input  logic          leakage,
    input  logic          lot_full,
    input  logic          issue_ready,
    input  logic          op_done,
    output logic          issue_valid,
    output logic [15:0]   issue_plate,
    output logic          issue_is_out,
    output logic          in_reject,
    output logic          out_reject,
    output logic [CW-1:0] in_count,
    output logic [CW-1:0] out_count,
    output logic          busy,
    output logic          timeout_err,
    output logic [1:0]    state_dbg
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = $clog2(OUT_BURST + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT_DONE = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   in_mem_q  [DEPTH];
    logic [15:0]   in_mem_d  [DEPTH];
    logic [15:0]   out_mem_q [DEPTH];
    logic [15:0]   out_mem_d [DEPTH];
    logic [PW-1:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d;
    logic [PW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
    logic [CW-1:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          valid_q, valid_d;
    logic [15:0]   plate_q, plate_d;
    logic          is_out_q, is_out_d;
    logic          in_rej_q, in_rej_d;
    logic          out_rej_q, out_rej_d;
    logic          terr_q, terr_d;

    logic          plate_ok, in_full, out_full;
    logic          in_push, out_push, in_pop, out_pop;

    always_comb begin
        plate_ok = (license_plate != '0);
        in_full  = (in_cnt_q == CW'(DEPTH));
        out_full = (out_cnt_q == CW'(DEPTH));

        // Simultaneous strobes are ambiguous, so neither side is accepted.
        in_push   = in_mode & ~out_mode & plate_ok & ~in_full & ~lot_full & ~leakage;
        out_push  = out_mode & ~in_mode & plate_ok & ~out_full;
        in_rej_d  = in_mode & ~in_push;
        out_rej_d = out_mode & ~out_push;

        state_d  = state_q;
        streak_d = streak_q;
        timer_d  = timer_q;
        valid_d  = valid_q;
        plate_d  = plate_q;
        is_out_d = is_out_q;
        terr_d   = terr_q;
        in_pop   = 1'b0;
        out_pop  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!leakage) begin
                    if ((out_cnt_q != '0) &&
                        ((streak_q < SW'(OUT_BURST)) || (in_cnt_q == '0))) begin
                        out_pop  = 1'b1;
                        plate_d  = out_mem_q[out_rd_q];
                        is_out_d = 1'b1;
                        valid_d  = 1'b1;
                        state_d  = S_ISSUE;
                        if (streak_q < SW'(OUT_BURST)) begin
                            streak_d = streak_q + SW'(1);
                        end
                    end else if (in_cnt_q != '0) begin
                        in_pop   = 1'b1;
                        plate_d  = in_mem_q[in_rd_q];
                        is_out_d = 1'b0;
                        valid_d  = 1'b1;
                        streak_d = '0;
                        state_d  = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (issue_ready) begin
                    valid_d = 1'b0;
                    timer_d = '0;
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (op_done) begin
                    state_d = S_IDLE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        in_mem_d  = in_mem_q;
        out_mem_d = out_mem_q;
        in_wr_d   = in_wr_q;
        in_rd_d   = in_rd_q;
        out_wr_d  = out_wr_q;
        out_rd_d  = out_rd_q;

        if (in_push) begin
            in_mem_d[in_wr_q] = license_plate;
            in_wr_d = in_wr_q + PW'(1);
        end
        if (out_push) begin
            out_mem_d[out_wr_q] = license_plate;
            out_wr_d = out_wr_q + PW'(1);
        end
        if (in_pop) begin
            in_rd_d = in_rd_q + PW'(1);
        end
        if (out_pop) begin
            out_rd_d = out_rd_q + PW'(1);
        end

        case ({in_push, in_pop})
            2'b10:   in_cnt_d = in_cnt_q + CW'(1);
            2'b01:   in_cnt_d = in_cnt_q - CW'(1);
            default: in_cnt_d = in_cnt_q;
        endcase
        case ({out_push, out_pop})
            2'b10:   out_cnt_d = out_cnt_q + CW'(1);
            2'b01:   out_cnt_d = out_cnt_q - CW'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            in_wr_q   <= '0;
            in_rd_q   <= '0;
            out_wr_q  <= '0;
            out_rd_q  <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            streak_q  <= '0;
            timer_q   <= '0;
            valid_q   <= 1'b0;
            plate_q   <= '0;
            is_out_q  <= 1'b0;
            in_rej_q  <= 1'b0;
            out_rej_q <= 1'b0;
            terr_q    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                in_mem_q[i]  <= '0;
                out_mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            in_wr_q   <= in_wr_d;
            in_rd_q   <= in_rd_d;
            out_wr_q  <= out_wr_d;
            out_rd_q  <= out_rd_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            streak_q  <= streak_d;
            timer_q   <= timer_d;
            valid_q   <= valid_d;
            plate_q   <= plate_d;
            is_out_q  <= is_out_d;
            in_rej_q  <= in_rej_d;
            out_rej_q <= out_rej_d;
            terr_q    <= terr_d;
            in_mem_q  <= in_mem_d;
            out_mem_q <= out_mem_d;
        end
    end

    assign issue_valid  = valid_q;
    assign issue_plate  = plate_q;
    assign issue_is_out = is_out_q;
    assign in_reject    = in_rej_q;
    assign out_reject   = out_rej_q;
    assign in_count     = in_cnt_q;
    assign out_count    = out_cnt_q;
    assign busy         = (state_q != S_IDLE);
    assign timeout_err  = terr_q;
    assign state_dbg    = state_q;

endmodule
